ysyx_24090012_ifu_fetch: RTL and testbench
==========================================

# ysyx_24090012_ifu_fetch

Instruction fetch stage: owns the architectural fetch PC, issues one AXI4-Lite-style read per instruction to the instruction memory port, and presents `inst`, `pc`, and a sequence tag to the decode stage over the `ifu_valid`/`ifu_ready` handshake. It is the producer end of the fetch→decode interface. It redirects on `control_hazard`/`branch_target_pc` from decode and discards any wrong-path data in flight.

## Interface
- `RESET_PC`, default 32'h3000_0000: first fetch address after reset.
- `NUM_W`, default 64: width of the instruction sequence tag.

- `clock`  in  1  clock.
- `reset`  in  1  asynchronous, active-high reset.
- `mem_arvalid`  out  1  read address valid.
- `mem_araddr`  out  32  read address; always the fetch PC, word aligned.
- `mem_arready`  in  1  read address accepted.
- `mem_rvalid`  in  1  read data valid.
- `mem_rdata`  in  32  instruction word.
- `mem_rresp`  in  2  response; 2'b00 OKAY, any other value is an error.
- `mem_rready`  out  1  read data ready.
- `ifu_valid`  out  1  `inst`/`ifu_to_idu_pc`/`num` valid toward decode.
- `ifu_ready`  in  1  decode can accept.
- `inst`  out  32  fetched instruction.
- `ifu_to_idu_pc`  out  32  PC of `inst`.
- `num`  out  NUM_W  sequence tag of `inst`. Starts at 1 and increments per accepted transfer.
- `control_hazard`  in  1  redirect request from decode.
- `branch_target_pc`  in  32  redirect target; sampled only when `control_hazard`=1.
- `fetch_err`  out  1  sticky flag: a memory error response halted fetch.

## Operation
- FSM states:
  - `BOOT`: the reset state; held for one cycle after reset release.
  - `REQ`: `mem_arvalid`=1, `mem_araddr`=pc.
  - `WAIT`: `mem_rready`=1.
  - `HOLD`: instruction buffered.
  - `ERR`: terminal.
- Transitions:
  - BOOT→REQ unconditionally.
  - REQ→WAIT on `mem_arready`.
  - WAIT→HOLD on `mem_rvalid` with OKAY and no pending flush.
  - WAIT→REQ on `mem_rvalid` with a pending flush.
  - WAIT→ERR on `mem_rvalid` with a non-OKAY response and no pending flush.
  - HOLD→REQ on a handshake or on `control_hazard`.
- `mem_araddr` stays stable while `mem_arvalid`=1; it never changes mid-request.
- Capture: on a WAIT response, `inst_r`←`mem_rdata` and `pc_out_r`←pc.
- `ifu_valid` = (state==HOLD) && !`control_hazard`. Decode never sees a wrong-path instruction in the redirect cycle.
- Handshake = `ifu_valid` && `ifu_ready`. On a handshake: pc←pc+4 (32-bit wrap, no carry out) and `num`←`num`+1 (NUM_W wrap).
- Redirect (`control_hazard`=1), by state:
  - HOLD: drop the buffered instruction; pc←`branch_target_pc`; go to REQ. `num` is not advanced.
  - REQ or WAIT: set `flush_pend` and latch pc←`branch_target_pc`. The outstanding AR/R transaction completes normally, and its response is discarded regardless of `mem_rresp`. Then go to REQ with the new pc and clear `flush_pend`.
  - Repeated redirects while pending: the last target wins.
  - BOOT: pc←target; BOOT→REQ still applies.
  - ERR: ignored.
- Error: `fetch_err`←1 and the FSM stays in ERR until reset. In ERR, `mem_arvalid`, `mem_rready` and `ifu_valid` are all 0.
- `branch_target_pc` bits [1:0] are forced to 0 when loaded.

## Timing
- Reset values:
  - state=BOOT, pc=`RESET_PC`, `num`=1, `inst`=0, `ifu_to_idu_pc`=0, `flush_pend`=0, `fetch_err`=0.
  - `mem_arvalid`, `mem_rready` and `ifu_valid` are 0 during reset and during BOOT.
- Reset asserted mid-transaction: all state clears immediately. The memory side must tolerate the abandoned request.
- Zero-wait memory (`mem_arready`=1 in REQ, `mem_rvalid`=1 first WAIT cycle):
  - `ifu_valid` rises 2 cycles after REQ entry.
  - Throughput is one instruction per 3 cycles when `ifu_ready` is held at 1.
- `ifu_valid`, `inst`, `ifu_to_idu_pc` and `num` are held stable in HOLD until the handshake. `ifu_valid` drops only via a handshake or `control_hazard`.
- The redirect target is fetched in the first REQ cycle after the redirect (HOLD case), or after the in-flight response retires (REQ/WAIT case).

## Configuration
- `IFU_PERF_EN` defined: three 32-bit counters, reset to 0 and readable via hierarchical reference.
  - `fetch_cnt` counts handshakes.
  - `flush_cnt` counts cycles where `control_hazard` is accepted.
  - `mem_stall_cnt` counts cycles in REQ with `mem_arready`=0 plus cycles in WAIT with `mem_rvalid`=0.
- `IFU_PERF_EN` undefined: no counters are instantiated. Functional behaviour is identical in both cases.

## Structure
- Shared package holds:
  - FSM state encoding (`IFU_BOOT`, `IFU_REQ`, `IFU_WAIT`, `IFU_HOLD`, `IFU_ERR`).
  - `RESP_OKAY` constant.
  - Default `RESET_PC`.
- One sub-module, `ysyx_24090012_ifu_pc`: holds the pc register and `num` register. It implements +4 advance, redirect load and `flush_pend`. The FSM remains in the top module.

## Test plan
- **Reset then zero-wait memory with `ifu_ready`=1:**
  - First `mem_araddr`=0x3000_0000.
  - First handshake carries pc 0x3000_0000 and `num`=1.
  - Second handshake carries pc 0x3000_0004 and `num`=2, exactly 3 cycles later.
- **`ifu_ready`=0 for 5 cycles in HOLD:** `ifu_valid`, `inst` and `num` are stable throughout, and no new AR is issued.
- **`control_hazard`=1 in HOLD with target 0x3000_0100:**
  - `ifu_valid`=0 in that cycle.
  - The next AR address is 0x3000_0100.
  - The next delivered `num` equals the dropped one.
- **`control_hazard` pulse while WAIT with rvalid delayed 4 cycles, target 0x3000_0200:** that response is never presented to decode, and the next AR address is 0x3000_0200.
- **`mem_rresp`=2'b10 on a fetch:** `fetch_err`=1; no further AR and no `ifu_valid` until reset.
- **Reset asserted during WAIT, then released:** outputs return to reset values, and fetch restarts at `RESET_PC` with `num`=1.

Source files
------------

// File: rtl/ysyx_24090012_ifu_fetch_pkg.sv
// ysyx_24090012_ifu_fetch_pkg: shared FSM encoding, response code and reset PC for the fetch stage
package ysyx_24090012_ifu_fetch_pkg;
  typedef enum logic [2:0] {IFU_BOOT, IFU_REQ, IFU_WAIT, IFU_HOLD, IFU_ERR} ifu_state_e;
  localparam logic [1:0] RESP_OKAY = 2'b00;
  localparam logic [31:0] DEF_RESET_PC = 32'h3000_0000;
  function automatic logic [31:0] word_align(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction
endpackage

// File: rtl/ysyx_24090012_ifu_fetch_if.sv
// ysyx_24090012_ifu_fetch_if: instruction memory read port plus fetch-to-decode handshake
interface ysyx_24090012_ifu_fetch_if #(parameter int NUM_W = 64);
  logic mem_arvalid;
  logic [31:0] mem_araddr;
  logic mem_arready;
  logic mem_rvalid;
  logic [31:0] mem_rdata;
  logic [1:0] mem_rresp;
  logic mem_rready;
  logic ifu_valid;
  logic ifu_ready;
  logic [31:0] inst;
  logic [31:0] ifu_to_idu_pc;
  logic [NUM_W-1:0] num;
  logic control_hazard;
  logic [31:0] branch_target_pc;
  logic fetch_err;
  modport master(
    output mem_arvalid, mem_araddr, mem_rready, ifu_valid, inst, ifu_to_idu_pc, num, fetch_err,
    input mem_arready, mem_rvalid, mem_rdata, mem_rresp, ifu_ready, control_hazard, branch_target_pc
  );
  modport slave(
    input mem_arvalid, mem_araddr, mem_rready, ifu_valid, inst, ifu_to_idu_pc, num, fetch_err,
    output mem_arready, mem_rvalid, mem_rdata, mem_rresp, ifu_ready, control_hazard, branch_target_pc
  );
endinterface

// File: rtl/ysyx_24090012_ifu_fetch_pc.sv
// ysyx_24090012_ifu_pc: fetch PC, sequence tag and pending-flush flag
module ysyx_24090012_ifu_pc
  import ysyx_24090012_ifu_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEF_RESET_PC,
  parameter int NUM_W = 64
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             i_adv,
  input  logic             i_redirect,
  input  logic [31:0]      i_target,
  input  logic             i_flush_set,
  input  logic             i_flush_clr,
  output logic [31:0]      o_pc,
  output logic [31:0]      o_pc_nxt,
  output logic [NUM_W-1:0] o_num,
  output logic             o_flush_pend
);
  logic [31:0] r_pc;
  logic [NUM_W-1:0] r_num;
  logic r_flush;
  assign o_pc_nxt = i_redirect ? word_align(i_target) : i_adv ? r_pc + 32'd4 : r_pc;
  assign o_pc = r_pc;
  assign o_num = r_num;
  assign o_flush_pend = r_flush;
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      r_pc <= RESET_PC;
      r_num <= NUM_W'(1);
      r_flush <= 1'b0;
    end else begin
      r_pc <= o_pc_nxt;
      r_num <= i_adv ? r_num + NUM_W'(1) : r_num;
      r_flush <= i_flush_set ? 1'b1 : i_flush_clr ? 1'b0 : r_flush;
    end
endmodule

// File: rtl/ysyx_24090012_ifu_fetch.sv
// ysyx_24090012_ifu_fetch: fetch FSM driving imem reads and the decode handshake; define IFU_PERF_EN for perf counters
module ysyx_24090012_ifu_fetch
  import ysyx_24090012_ifu_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEF_RESET_PC,
  parameter int NUM_W = 64
) (
  input logic clock,
  input logic reset,
  ysyx_24090012_ifu_fetch_if.master bus
);
  ifu_state_e r_state;
  logic [31:0] r_araddr, r_inst, r_pc_out, w_pc, w_pc_nxt;
  logic [NUM_W-1:0] w_num;
  logic r_err, w_fire, w_redirect, w_flush_pend, w_resp, w_discard, w_flush_set;
  assign w_redirect = bus.control_hazard && r_state != IFU_ERR;
  assign w_fire = bus.ifu_valid && bus.ifu_ready;
  assign w_resp = r_state == IFU_WAIT && bus.mem_rvalid;
  assign w_discard = w_flush_pend || bus.control_hazard;
  // a hazard landing on the response cycle discards that response directly instead of pending
  assign w_flush_set = bus.control_hazard && (r_state == IFU_REQ || (r_state == IFU_WAIT && !bus.mem_rvalid));
  ysyx_24090012_ifu_pc #(.RESET_PC(RESET_PC), .NUM_W(NUM_W)) u_pc (
    .clock(clock),
    .reset(reset),
    .i_adv(w_fire),
    .i_redirect(w_redirect),
    .i_target(bus.branch_target_pc),
    .i_flush_set(w_flush_set),
    .i_flush_clr(w_resp),
    .o_pc(w_pc),
    .o_pc_nxt(w_pc_nxt),
    .o_num(w_num),
    .o_flush_pend(w_flush_pend)
  );
  assign bus.mem_arvalid = r_state == IFU_REQ;
  assign bus.mem_araddr = r_araddr;
  assign bus.mem_rready = r_state == IFU_WAIT;
  assign bus.ifu_valid = r_state == IFU_HOLD && !bus.control_hazard;
  assign bus.inst = r_inst;
  assign bus.ifu_to_idu_pc = r_pc_out;
  assign bus.num = w_num;
  assign bus.fetch_err = r_err;
  // the request address is latched on REQ entry so a redirect never disturbs a live AR
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      r_state <= IFU_BOOT;
      r_araddr <= RESET_PC;
      r_inst <= '0;
      r_pc_out <= '0;
      r_err <= 1'b0;
    end else
      case (r_state)
        IFU_BOOT: begin
          r_state <= IFU_REQ;
          r_araddr <= w_pc_nxt;
        end
        IFU_REQ: if (bus.mem_arready) r_state <= IFU_WAIT;
        IFU_WAIT: if (bus.mem_rvalid) begin
          if (w_discard) begin
            r_state <= IFU_REQ;
            r_araddr <= w_pc_nxt;
          end else if (bus.mem_rresp == RESP_OKAY) begin
            r_state <= IFU_HOLD;
            r_inst <= bus.mem_rdata;
            r_pc_out <= w_pc;
          end else begin
            r_state <= IFU_ERR;
            r_err <= 1'b1;
          end
        end
        IFU_HOLD: if (w_fire || bus.control_hazard) begin
          r_state <= IFU_REQ;
          r_araddr <= w_pc_nxt;
        end
        default: ;
      endcase
`ifdef IFU_PERF_EN
  logic [31:0] fetch_cnt, flush_cnt, mem_stall_cnt;
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      fetch_cnt <= '0;
      flush_cnt <= '0;
      mem_stall_cnt <= '0;
    end else begin
      fetch_cnt <= fetch_cnt + 32'(w_fire);
      flush_cnt <= flush_cnt + 32'(w_redirect);
      mem_stall_cnt <= mem_stall_cnt + 32'((r_state == IFU_REQ && !bus.mem_arready) || (r_state == IFU_WAIT && !bus.mem_rvalid));
    end
`else
  // counters are left out entirely when perf monitoring is not built in
`endif
endmodule

// File: tb/tb_ysyx_24090012_ifu_fetch.sv
// tb_ysyx_24090012_ifu_fetch: directed vectors and corner sequences against a latency-programmable memory responder
module tb_ysyx_24090012_ifu_fetch;
  localparam logic [31:0] RPC = 32'h3000_0000;
  typedef struct {int ar_lat; int r_lat; logic [31:0] pc; logic [63:0] num;} vec_t;
  typedef struct {logic [31:0] pc; logic [63:0] num; logic [31:0] inst; int cyc;} dlv_t;
  logic clock = 1'b0, reset = 1'b1;
  int n_chk = 0, n_fail = 0, cyc = 0;
  int ar_lat = 0, r_lat = 0, mcnt = 0;
  bit busy = 0;
  logic [31:0] maddr = '0, err_addr = 32'hFFFF_FFFF;
  logic [31:0] ar_q[$];
  dlv_t dq[$];
  vec_t vecs[5];
  ysyx_24090012_ifu_fetch_if #(.NUM_W(64)) bus();
  ysyx_24090012_ifu_fetch dut(.clock(clock), .reset(reset), .bus(bus.master));
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;
  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return a ^ 32'hA5A5_0F0F;
  endfunction
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic drv();
    @(posedge clock);
    #2;
  endtask
  task automatic pulse();
    drv();
    bus.ifu_ready = 1'b1;
    drv();
    bus.ifu_ready = 1'b0;
  endtask
  task automatic wait_valid(output int n);
    n = 0;
    while (!bus.ifu_valid && n < 200) begin
      @(negedge clock);
      n++;
    end
    chk("valid_timeout", 64'(n < 200), 64'd1);
  endtask
  task automatic wait_rready();
    int n = 0;
    while (!bus.mem_rready && n < 100) begin
      @(negedge clock);
      n++;
    end
    chk("rready_timeout", 64'(n < 100), 64'd1);
  endtask
  initial begin
    bus.mem_arready = 1'b0;
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata = '0;
    bus.mem_rresp = 2'b00;
    forever begin
      @(posedge clock);
      #1;
      if (reset) begin
        bus.mem_arready = 1'b0;
        bus.mem_rvalid = 1'b0;
        busy = 0;
        mcnt = 0;
      end else begin
        if (bus.mem_rvalid) begin
          bus.mem_rvalid = 1'b0;
          busy = 0;
          mcnt = 0;
        end
        if (bus.mem_arready) begin
          bus.mem_arready = 1'b0;
          busy = 1;
          mcnt = 0;
        end else if (bus.mem_arvalid && !busy) begin
          if (mcnt >= ar_lat) begin
            bus.mem_arready = 1'b1;
            maddr = bus.mem_araddr;
            ar_q.push_back(bus.mem_araddr);
          end else mcnt++;
        end
        if (busy && !bus.mem_rvalid) begin
          if (mcnt >= r_lat) begin
            bus.mem_rvalid = 1'b1;
            bus.mem_rdata = inst_of(maddr);
            bus.mem_rresp = maddr == err_addr ? 2'b10 : 2'b00;
          end else mcnt++;
        end
      end
    end
  end
  always @(negedge clock)
    if (bus.ifu_valid && bus.ifu_ready) dq.push_back('{bus.ifu_to_idu_pc, bus.num, bus.inst, cyc});
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    int n, qs, aq;
    bit s_arv, s_val, s_rr, s_chg;
    logic [31:0] h_inst, h_pc;
    logic [63:0] h_num;
    vecs[0] = '{0, 0, 32'h3000_000C, 64'd4};
    vecs[1] = '{2, 0, 32'h3000_0010, 64'd5};
    vecs[2] = '{0, 3, 32'h3000_0014, 64'd6};
    vecs[3] = '{1, 1, 32'h3000_0018, 64'd7};
    vecs[4] = '{3, 2, 32'h3000_001C, 64'd8};
    bus.ifu_ready = 1'b1;
    bus.control_hazard = 1'b0;
    bus.branch_target_pc = '0;
    repeat (3) @(negedge clock);
    chk("rst_arvalid", 64'(bus.mem_arvalid), 64'd0);
    chk("rst_rready", 64'(bus.mem_rready), 64'd0);
    chk("rst_valid", 64'(bus.ifu_valid), 64'd0);
    chk("rst_inst", 64'(bus.inst), 64'd0);
    chk("rst_pc", 64'(bus.ifu_to_idu_pc), 64'd0);
    chk("rst_num", bus.num, 64'd1);
    chk("rst_err", 64'(bus.fetch_err), 64'd0);
    drv();
    reset = 1'b0;
    @(negedge clock);
    chk("boot_arvalid", 64'(bus.mem_arvalid), 64'd0);
    n = 0;
    while (dq.size() < 2 && n < 50) begin
      @(posedge clock);
      n++;
    end
    chk("first_two_timeout", 64'(dq.size() >= 2), 64'd1);
    drv();
    bus.ifu_ready = 1'b0;
    if (dq.size() >= 2) begin
      chk("first_araddr", 64'(ar_q[0]), 64'(RPC));
      chk("d0_pc", 64'(dq[0].pc), 64'(RPC));
      chk("d0_num", dq[0].num, 64'd1);
      chk("d0_inst", 64'(dq[0].inst), 64'(inst_of(RPC)));
      chk("d1_pc", 64'(dq[1].pc), 64'(RPC + 32'd4));
      chk("d1_num", dq[1].num, 64'd2);
      chk("d1_gap", 64'(dq[1].cyc - dq[0].cyc), 64'd3);
    end
    wait_valid(n);
    chk("hold_pc", 64'(bus.ifu_to_idu_pc), 64'h3000_0008);
    chk("hold_num", bus.num, 64'd3);
    h_inst = bus.inst;
    h_num = bus.num;
    h_pc = bus.ifu_to_idu_pc;
    aq = ar_q.size();
    s_chg = 0;
    s_arv = 0;
    repeat (5) begin
      @(negedge clock);
      if (!bus.ifu_valid || bus.inst !== h_inst || bus.num !== h_num || bus.ifu_to_idu_pc !== h_pc) s_chg = 1;
      if (bus.mem_arvalid) s_arv = 1;
    end
    chk("hold_stable", 64'(s_chg), 64'd0);
    chk("hold_no_arvalid", 64'(s_arv), 64'd0);
    chk("hold_no_ar", 64'(ar_q.size()), 64'(aq));
    for (int i = 0; i < 5; i++) begin
      ar_lat = vecs[i].ar_lat;
      r_lat = vecs[i].r_lat;
      pulse();
      wait_valid(n);
      chk($sformatf("vec%0d_pc", i), 64'(bus.ifu_to_idu_pc), 64'(vecs[i].pc));
      chk($sformatf("vec%0d_num", i), bus.num, vecs[i].num);
      chk($sformatf("vec%0d_inst", i), 64'(bus.inst), 64'(inst_of(vecs[i].pc)));
      chk($sformatf("vec%0d_lat", i), 64'(n), 64'(3 + vecs[i].ar_lat + vecs[i].r_lat));
      chk($sformatf("vec%0d_araddr", i), 64'(ar_q[$]), 64'(vecs[i].pc));
    end
    ar_lat = 0;
    r_lat = 0;
    qs = dq.size();
    drv();
    bus.control_hazard = 1'b1;
    bus.branch_target_pc = 32'h3000_0102;
    bus.ifu_ready = 1'b1;
    @(negedge clock);
    chk("hz_hold_valid", 64'(bus.ifu_valid), 64'd0);
    drv();
    bus.control_hazard = 1'b0;
    bus.ifu_ready = 1'b0;
    wait_valid(n);
    chk("hz_hold_pc", 64'(bus.ifu_to_idu_pc), 64'h3000_0100);
    chk("hz_hold_num", bus.num, 64'd8);
    chk("hz_hold_araddr", 64'(ar_q[$]), 64'h3000_0100);
    chk("hz_hold_no_xfer", 64'(dq.size()), 64'(qs));
    r_lat = 4;
    pulse();
    wait_rready();
    drv();
    bus.control_hazard = 1'b1;
    bus.branch_target_pc = 32'h3000_0200;
    drv();
    bus.control_hazard = 1'b0;
    wait_valid(n);
    chk("hz_wait_pc", 64'(bus.ifu_to_idu_pc), 64'h3000_0200);
    chk("hz_wait_inst", 64'(bus.inst), 64'(inst_of(32'h3000_0200)));
    chk("hz_wait_num", bus.num, 64'd9);
    chk("hz_wait_ar_old", 64'(ar_q[ar_q.size() - 2]), 64'h3000_0104);
    chk("hz_wait_ar_new", 64'(ar_q[$]), 64'h3000_0200);
    r_lat = 0;
    err_addr = 32'h3000_0204;
    pulse();
    n = 0;
    while (!bus.fetch_err && n < 50) begin
      @(negedge clock);
      n++;
    end
    chk("err_flag", 64'(bus.fetch_err), 64'd1);
    aq = ar_q.size();
    s_arv = 0;
    s_val = 0;
    s_rr = 0;
    bus.ifu_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drv();
      bus.control_hazard = i == 3;
      bus.branch_target_pc = 32'h3000_0400;
      @(negedge clock);
      if (bus.mem_arvalid) s_arv = 1;
      if (bus.ifu_valid) s_val = 1;
      if (bus.mem_rready) s_rr = 1;
    end
    chk("err_no_arvalid", 64'(s_arv), 64'd0);
    chk("err_no_valid", 64'(s_val), 64'd0);
    chk("err_no_rready", 64'(s_rr), 64'd0);
    chk("err_no_ar", 64'(ar_q.size()), 64'(aq));
    chk("err_sticky", 64'(bus.fetch_err), 64'd1);
    drv();
    reset = 1'b1;
    bus.control_hazard = 1'b0;
    bus.ifu_ready = 1'b0;
    err_addr = 32'hFFFF_FFFF;
    repeat (2) drv();
    reset = 1'b0;
    wait_valid(n);
    chk("rst2_pc", 64'(bus.ifu_to_idu_pc), 64'(RPC));
    chk("rst2_num", bus.num, 64'd1);
    r_lat = 5;
    pulse();
    wait_rready();
    drv();
    reset = 1'b1;
    #1;
    chk("rstw_arvalid", 64'(bus.mem_arvalid), 64'd0);
    chk("rstw_rready", 64'(bus.mem_rready), 64'd0);
    chk("rstw_valid", 64'(bus.ifu_valid), 64'd0);
    chk("rstw_inst", 64'(bus.inst), 64'd0);
    chk("rstw_pc", 64'(bus.ifu_to_idu_pc), 64'd0);
    chk("rstw_num", bus.num, 64'd1);
    chk("rstw_err", 64'(bus.fetch_err), 64'd0);
    r_lat = 0;
    repeat (2) drv();
    reset = 1'b0;
    wait_valid(n);
    chk("rstw_re_pc", 64'(bus.ifu_to_idu_pc), 64'(RPC));
    chk("rstw_re_num", bus.num, 64'd1);
    chk("rstw_re_inst", 64'(bus.inst), 64'(inst_of(RPC)));
    chk("rstw_re_araddr", 64'(ar_q[$]), 64'(RPC));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
